// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Definitions shared by the multiply/divide unit, the instruction decoder and
// the hazard unit:
//   md_op_e     - op encodings presented on the unit's op input (6-7 reserved)
//   md_state_e  - IDLE/RUN state encoding of the unit's sequencer
//   MD_MUL_CYC  - default number of busy cycles for mult/multu
//   MD_DIV_CYC  - default number of busy cycles for div/divu
//   md_cnt_width() - counter width able to hold the larger cycle count
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MUL_CYC = 5;
    localparam int MD_DIV_CYC = 10;

    // Width needed to hold max(mul_cyc, div_cyc); both counts must be >= 1.
    function automatic int md_cnt_width(input int mul_cyc, input int div_cyc);
        int max_cyc;
        max_cyc = (mul_cyc > div_cyc) ? mul_cyc : div_cyc;
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the EXE stage (master) and the multiply/divide
// unit (slave).
//   start - request strobe, qualifies op
//   op    - operation code (see md_op_e)
//   a     - rs operand: dividend, multiplicand or mthi/mtlo data
//   b     - rt operand: divisor or multiplier
//   busy  - operation in flight; stalls IF/ID and PC
//   hi    - HI register (mfhi)
//   lo    - LO register (mflo)
// -----------------------------------------------------------------------------
interface mult_div_unit_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// MIPS-style HI/LO multiply/divide unit with a fixed-latency busy window.
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high; aborts any operation in flight
//   md    - mult_div_unit_if.slave: start/op/a/b in, busy/hi/lo out
// Parameters:
//   MUL_CYC - busy cycles for mult/multu (>= 1)
//   DIV_CYC - busy cycles for div/divu   (>= 1)
//
// An accepted mult/div latches its operands and op, then counts down in RUN.
// The arithmetic is purely combinational on the latched copies and is only
// committed to HI/LO on the final RUN edge, so the requester's a/b may change
// freely while busy is high. mthi/mtlo write directly in IDLE with no stall.
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_CYC = MD_MUL_CYC,
    parameter int DIV_CYC = MD_DIV_CYC
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave md
);

    localparam int CNT_W = md_cnt_width(MUL_CYC, DIV_CYC);

    md_state_e          state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [2:0]         op_reg;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic               busy_reg;

    // Combinational result on the latched operands
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               res_valid;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    always_comb begin
        // Operands are sign/zero-extended to 64 bits so the low 64 bits of
        // the product are exact for both signednesses.
        prod_s    = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
        prod_u    = {32'd0, a_reg} * {32'd0, b_reg};
        div_zero  = (b_reg == 32'd0);
        res_valid = 1'b0;
        res_hi    = hi_reg;
        res_lo    = lo_reg;
        case (op_reg)
            MD_MULT: begin
                res_valid = 1'b1;
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
            end
            MD_MULTU: begin
                res_valid = 1'b1;
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
            end
            MD_DIV: begin
                // Signed / and % truncate toward zero; remainder follows the
                // dividend's sign. A zero divisor leaves HI/LO untouched.
                if (!div_zero) begin
                    res_valid = 1'b1;
                    res_lo    = $signed(a_reg) / $signed(b_reg);
                    res_hi    = $signed(a_reg) % $signed(b_reg);
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    res_valid = 1'b1;
                    res_lo    = a_reg / b_reg;
                    res_hi    = a_reg % b_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= MD_IDLE;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (md.start) begin
                        case (md.op)
                            MD_MULT, MD_MULTU: begin
                                op_reg    <= md.op;
                                a_reg     <= md.a;
                                b_reg     <= md.b;
                                count_reg <= CNT_W'(MUL_CYC);
                                state_reg <= MD_RUN;
                                busy_reg  <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                op_reg    <= md.op;
                                a_reg     <= md.a;
                                b_reg     <= md.b;
                                count_reg <= CNT_W'(DIV_CYC);
                                state_reg <= MD_RUN;
                                busy_reg  <= 1'b1;
                            end
                            MD_MTHI: hi_reg <= md.a;
                            MD_MTLO: lo_reg <= md.a;
                            default: ;  // reserved ops are dropped
                        endcase
                    end
                end
                MD_RUN: begin
                    // start is deliberately not looked at here; the hazard
                    // unit holds the requester while busy is high.
                    if (count_reg == CNT_W'(1)) begin
                        if (res_valid) begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                        count_reg <= '0;
                        state_reg <= MD_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= MD_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy = busy_reg;
    assign md.hi   = hi_reg;
    assign md.lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit with default MUL_CYC=5 / DIV_CYC=10.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there,
// so every check sees the state settled by the preceding edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mult_div_unit_if md_if();

    mult_div_unit #(
        .MUL_CYC (5),
        .DIV_CYC (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.a     = a;
        md_if.b     = b;
        step();
        md_if.start = 1'b0;
        $display("[TB] issue op=%0d a=%08h b=%08h -> busy=%0b hi=%08h lo=%08h",
                 op, a, b, md_if.busy, md_if.hi, md_if.lo);
    endtask

    // Count remaining busy cycles (including the current one), bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (md_if.busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
        $display("[TB] done after %0d busy cycles hi=%08h lo=%08h", n, md_if.hi, md_if.lo);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        md_if.start = 1'b1;          // reset must win over start
        md_if.op    = MD_MULT;
        md_if.a     = 32'd5;
        md_if.b     = 32'd5;
        step(); step(); step();
        tests_run++;
        if (md_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", md_if.busy); end
        tests_run++;
        if (md_if.hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %08h want 00000000", md_if.hi); end
        tests_run++;
        if (md_if.lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %08h want 00000000", md_if.lo); end
        reset       = 1'b0;
        md_if.start = 1'b0;
        step();
        tests_run++;
        if (md_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %0b want 0", md_if.busy); end
        $display("[TB] reset done busy=%0b hi=%08h lo=%08h", md_if.busy, md_if.hi, md_if.lo);
    endtask

    task automatic test_mult();
        int n;
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        tests_run++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
            tests_failed++; $display("FAIL mult_early_write: got hi=%08h lo=%08h want 0/0", md_if.hi, md_if.lo);
        end
        wait_idle(n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL mult_cycles: got %0d want 5", n); end
        tests_run++;
        if (md_if.hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi: got %08h want ffffffff", md_if.hi); end
        tests_run++;
        if (md_if.lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mult_lo: got %08h want fffffffe", md_if.lo); end
    endtask

    task automatic test_multu();
        int n;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL multu_cycles: got %0d want 5", n); end
        tests_run++;
        if (md_if.hi !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_hi: got %08h want 00000001", md_if.hi); end
        tests_run++;
        if (md_if.lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_lo: got %08h want fffffffe", md_if.lo); end
    endtask

    task automatic test_div();
        int n;
        // -7 / 2 = -3 rem -1; operands scrambled while busy must not matter
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        md_if.a = 32'd100;
        md_if.b = 32'd3;
        md_if.op = MD_MULTU;
        wait_idle(n);
        tests_run++;
        if (n !== 10) begin tests_failed++; $display("FAIL div_cycles: got %0d want 10", n); end
        tests_run++;
        if (md_if.lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_lo: got %08h want fffffffd", md_if.lo); end
        tests_run++;
        if (md_if.hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_hi: got %08h want ffffffff", md_if.hi); end
        // 7 / -2 = -3 rem 1
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        tests_run++;
        if (md_if.lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_lo: got %08h want fffffffd", md_if.lo); end
        tests_run++;
        if (md_if.hi !== 32'h0000_0001) begin tests_failed++; $display("FAIL div_neg_hi: got %08h want 00000001", md_if.hi); end
        // 0xFFFFFFF9 unsigned / 2 = 0x7FFFFFFC rem 1
        issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        tests_run++;
        if (md_if.lo !== 32'h7FFF_FFFC) begin tests_failed++; $display("FAIL divu_lo: got %08h want 7ffffffc", md_if.lo); end
        // 100 / 7 = 14 rem 2
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        tests_run++;
        if (md_if.lo !== 32'd14 || md_if.hi !== 32'd2) begin
            tests_failed++; $display("FAIL divu_100_7: got hi=%08h lo=%08h want 00000002/0000000e", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_div_zero();
        int n;
        issue(MD_DIVU, 32'd7, 32'd0);
        wait_idle(n);
        tests_run++;
        if (n !== 10) begin tests_failed++; $display("FAIL divzero_cycles: got %0d want 10", n); end
        tests_run++;
        if (md_if.hi !== 32'd2) begin tests_failed++; $display("FAIL divzero_hi: got %08h want 00000002", md_if.hi); end
        tests_run++;
        if (md_if.lo !== 32'd14) begin tests_failed++; $display("FAIL divzero_lo: got %08h want 0000000e", md_if.lo); end
    endtask

    task automatic test_mthi_mtlo();
        int n;
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        tests_run++;
        if (md_if.busy !== 1'b0) begin tests_failed++; $display("FAIL mthi_busy: got %0b want 0", md_if.busy); end
        tests_run++;
        if (md_if.hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL mthi_hi: got %08h want 12345678", md_if.hi); end
        tests_run++;
        if (md_if.lo !== 32'd14) begin tests_failed++; $display("FAIL mthi_lo_kept: got %08h want 0000000e", md_if.lo); end
        issue(MD_MTLO, 32'hCAFE_BABE, 32'd0);
        tests_run++;
        if (md_if.lo !== 32'hCAFE_BABE) begin tests_failed++; $display("FAIL mtlo_lo: got %08h want cafebabe", md_if.lo); end
        // mtlo arriving while a mult is running must be dropped
        issue(MD_MULT, 32'd3, 32'd4);
        issue(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        tests_run++;
        if (md_if.lo !== 32'hCAFE_BABE || md_if.busy !== 1'b1) begin
            tests_failed++; $display("FAIL mtlo_while_busy: got lo=%08h busy=%0b want cafebabe/1", md_if.lo, md_if.busy);
        end
        wait_idle(n);
        tests_run++;
        if (md_if.lo !== 32'd12 || md_if.hi !== 32'd0) begin
            tests_failed++; $display("FAIL mult_after_mtlo: got hi=%08h lo=%08h want 00000000/0000000c", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_reserved();
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'h5555_5555, 32'd1);
        step();
        tests_run++;
        if (md_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reserved_busy: got %0b want 0", md_if.busy); end
        tests_run++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd12) begin
            tests_failed++; $display("FAIL reserved_hilo: got hi=%08h lo=%08h want 00000000/0000000c", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_reset_abort();
        issue(MD_MTHI, 32'h1111_1111, 32'd0);
        issue(MD_DIV, 32'd100, 32'd3);   // now in busy cycle 1
        step(); step(); step();          // busy cycle 4
        tests_run++;
        if (md_if.busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_busy: got %0b want 1", md_if.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("[TB] reset during div busy=%0b hi=%08h lo=%08h", md_if.busy, md_if.hi, md_if.lo);
        tests_run++;
        if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
            tests_failed++; $display("FAIL abort_state: got busy=%0b hi=%08h lo=%08h want 0/0/0", md_if.busy, md_if.hi, md_if.lo);
        end
        for (int i = 0; i < 12; i++) step();
        tests_run++;
        if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
            tests_failed++; $display("FAIL abort_late_write: got busy=%0b hi=%08h lo=%08h want 0/0/0", md_if.busy, md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int n2;
        bit hold_ok;
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        tests_run++;
        if (n !== 5 || md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFE) begin
            tests_failed++; $display("FAIL b2b_first: got n=%0d hi=%08h lo=%08h want 5/ffffffff/fffffffe", n, md_if.hi, md_if.lo);
        end
        // Second request raised in the cycle busy has just fallen
        issue(MD_MULT, 32'd3, 32'd5);
        tests_run++;
        if (md_if.busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy=%0b want 1", md_if.busy); end
        hold_ok = 1'b1;
        n2 = 0;
        while (md_if.busy === 1'b1 && n2 < 64) begin
            if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFE) hold_ok = 1'b0;
            n2++;
            step();
        end
        $display("[TB] second mult done after %0d busy cycles hi=%08h lo=%08h", n2, md_if.hi, md_if.lo);
        tests_run++;
        if (hold_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold: got %0b want 1 (first result held)", hold_ok); end
        tests_run++;
        if (n2 !== 5) begin tests_failed++; $display("FAIL b2b_cycles: got %0d want 5", n2); end
        tests_run++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd15) begin
            tests_failed++; $display("FAIL b2b_second: got hi=%08h lo=%08h want 00000000/0000000f", md_if.hi, md_if.lo);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        md_if.start  = 1'b0;
        md_if.op     = 3'd0;
        md_if.a      = 32'd0;
        md_if.b      = 32'd0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_reserved();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
